wb_pipe_stage: RTL and testbench

- Parametrised memory-response/writeback stage of the RISC-V core, the successor to the single-register writeback stage.
- Carries in-flight instructions through a configurable-depth shift pipeline that matches the data-memory read latency.
- Aligns and sign/zero-extends load data, selects the writeback source, and drives the register-file write port.
- Adds stall/flush control, a load-use hazard detector, and a retired-instruction counter.

---
 rtl/riscv_wb_pkg.sv | 44 ++++
 rtl/wb_load_align.sv | 54 +++++
 rtl/wb_pipe_stage.sv | 137 +++++++++++++
 tb/tb_wb_pipe_stage.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_wb_pkg.sv
// Shared constants and writeback-source decode for the memory-response/writeback stage.
package riscv_wb_pkg;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic [2:0] {
        WB_NONE = 3'd0,
        WB_ALU  = 3'd1,
        WB_MEM  = 3'd2,
        WB_PC4  = 3'd3,
        WB_IMM  = 3'd4
    } wb_sel_e;

    // The *-32 opcodes only exist on RV64; on RV32 they never write rd.
    function automatic wb_sel_e wb_sel_decode(input logic [6:0] opcode, input logic is_rv64);
        wb_sel_e sel;
        case (opcode)
            OPC_LUI:                        sel = WB_IMM;
            OPC_AUIPC, OPC_OP_IMM, OPC_OP:  sel = WB_ALU;
            OPC_OP_IMM_32, OPC_OP_32:       sel = is_rv64 ? WB_ALU : WB_NONE;
            OPC_JAL, OPC_JALR:              sel = WB_PC4;
            OPC_LOAD:                       sel = WB_MEM;
            default:                        sel = WB_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/wb_load_align.sv
// Load-data alignment and sign/zero extension; low offset bits below the access size are ignored.
module wb_load_align
    import riscv_wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]             rdata,
    input  logic [$clog2(XLEN/8)-1:0]   off,
    input  logic [2:0]                  funct3,
    output logic [XLEN-1:0]             data,
    output logic                        legal
);

    logic [5:0]  off_s;
    logic [5:0]  byte_sh_s;
    logic [5:0]  half_sh_s;
    logic [5:0]  word_sh_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [31:0] word_s;

    // Extract the addressed lane and extend it to XLEN
    always_comb begin
        off_s     = 6'(off);
        byte_sh_s = off_s << 3'd3;
        half_sh_s = {off_s[5:1], 1'b0} << 3'd3;
        word_sh_s = {off_s[5:2], 2'b00} << 3'd3;
        byte_s    = 8'(rdata >> byte_sh_s);
        half_s    = 16'(rdata >> half_sh_s);
        word_s    = 32'(rdata >> word_sh_s);
        data      = {XLEN{1'b0}};
        legal     = 1'b1;
        case (funct3)
            F3_LB:  data = XLEN'($signed(byte_s));
            F3_LBU: data = XLEN'(byte_s);
            F3_LH:  data = XLEN'($signed(half_s));
            F3_LHU: data = XLEN'(half_s);
            F3_LW:  data = XLEN'($signed(word_s));
            F3_LWU: begin
                legal = (XLEN == 64);
                data  = (XLEN == 64) ? XLEN'(word_s) : {XLEN{1'b0}};
            end
            F3_LD: begin
                legal = (XLEN == 64);
                data  = (XLEN == 64) ? rdata : {XLEN{1'b0}};
            end
            default: begin
                legal = 1'b0;
                data  = {XLEN{1'b0}};
            end
        endcase
    end

endmodule

// File: rtl/wb_pipe_stage.sv
// Memory-response/writeback stage: MEM_LAT-deep instruction pipeline, load alignment,
// register-file write port, load-use hazard detection and retired-instruction counter.
module wb_pipe_stage
    import riscv_wb_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int MEM_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            in_valid,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_alu,
    input  logic [XLEN-1:0] in_pc4,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic [4:0]      haz_rs1,
    input  logic [4:0]      haz_rs2,
    output logic            wb_en,
    output logic [4:0]      wb_addr,
    output logic [XLEN-1:0] wb_data,
    output logic            load_hazard,
    output logic [63:0]     instret
);

    localparam int HEAD = MEM_LAT - 1;
    localparam int OFFW = $clog2(XLEN / 8);

    logic            valid_r [MEM_LAT];
    logic [31:0]     inst_r  [MEM_LAT];
    logic [XLEN-1:0] alu_r   [MEM_LAT];
    logic [XLEN-1:0] pc4_r   [MEM_LAT];
    logic [XLEN-1:0] imm_r   [MEM_LAT];
    logic [63:0]     instret_r;

    logic [6:0]      head_op_s;
    logic [4:0]      head_rd_s;
    logic [2:0]      head_f3_s;
    logic [16:0]     unused_inst_s;
    wb_sel_e         wb_sel_s;
    logic [XLEN-1:0] sel_data_s;
    logic            sel_legal_s;
    logic [XLEN-1:0] load_data_s;
    logic            load_legal_s;
    logic            hazard_s;

    // Entry pipeline and retire counter; flush never kills the head
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                valid_r[i] <= 1'b0;
                inst_r[i]  <= 32'd0;
                alu_r[i]   <= {XLEN{1'b0}};
                pc4_r[i]   <= {XLEN{1'b0}};
                imm_r[i]   <= {XLEN{1'b0}};
            end
            instret_r <= 64'd0;
        end else if (stall) begin
            if (flush) begin
                for (int i = 0; i < HEAD; i++) begin
                    valid_r[i] <= 1'b0;
                end
            end
        end else begin
            valid_r[0] <= in_valid & ~flush;
            inst_r[0]  <= in_inst;
            alu_r[0]   <= in_alu;
            pc4_r[0]   <= in_pc4;
            imm_r[0]   <= in_imm;
            for (int i = 1; i < MEM_LAT; i++) begin
                valid_r[i] <= valid_r[i-1] & ~flush;
                inst_r[i]  <= inst_r[i-1];
                alu_r[i]   <= alu_r[i-1];
                pc4_r[i]   <= pc4_r[i-1];
                imm_r[i]   <= imm_r[i-1];
            end
            if (valid_r[HEAD]) begin
                instret_r <= instret_r + 64'd1;
            end
        end
    end

    assign head_op_s     = inst_r[HEAD][6:0];
    assign head_rd_s     = inst_r[HEAD][11:7];
    assign head_f3_s     = inst_r[HEAD][14:12];
    assign unused_inst_s = inst_r[HEAD][31:15];
    assign instret       = instret_r;

    wb_load_align #(.XLEN(XLEN)) u_load_align (
        .rdata  (mem_rdata),
        .off    (alu_r[HEAD][OFFW-1:0]),
        .funct3 (head_f3_s),
        .data   (load_data_s),
        .legal  (load_legal_s)
    );

    // Writeback source select and write-port gating
    always_comb begin
        wb_sel_s    = wb_sel_decode(head_op_s, XLEN == 64);
        sel_data_s  = {XLEN{1'b0}};
        sel_legal_s = 1'b1;
        case (wb_sel_s)
            WB_ALU: sel_data_s = alu_r[HEAD];
            WB_PC4: sel_data_s = pc4_r[HEAD];
            WB_IMM: sel_data_s = imm_r[HEAD];
            WB_MEM: begin
                sel_data_s  = load_data_s;
                sel_legal_s = load_legal_s;
            end
            default: sel_legal_s = 1'b0;
        endcase
        if (rst || !valid_r[HEAD]) begin
            wb_en   = 1'b0;
            wb_addr = 5'd0;
            wb_data = {XLEN{1'b0}};
        end else begin
            wb_en   = ~stall & sel_legal_s & (head_rd_s != 5'd0);
            wb_addr = head_rd_s;
            wb_data = sel_legal_s ? sel_data_s : {XLEN{1'b0}};
        end
    end

    // Load-use hazard across every in-flight entry, head included
    always_comb begin
        hazard_s = 1'b0;
        for (int i = 0; i < MEM_LAT; i++) begin
            hazard_s = hazard_s |
                (valid_r[i] && (inst_r[i][6:0] == OPC_LOAD) && (inst_r[i][11:7] != 5'd0) &&
                 (((haz_rs1 != 5'd0) && (haz_rs1 == inst_r[i][11:7])) ||
                  ((haz_rs2 != 5'd0) && (haz_rs2 == inst_r[i][11:7]))));
        end
        load_hazard = hazard_s & ~rst;
    end

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Bench for wb_pipe_stage: three instances (MEM_LAT 1..3) share one stimulus stream and are
// compared against a capture-history reference model, plus directed checks.
module tb_wb_pipe_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, in_valid;
    logic [31:0] in_inst, in_alu, in_pc4, in_imm, mem_rdata;
    logic [4:0]  haz_rs1, haz_rs2;
    logic [2:0]  en, haz;
    logic [4:0]  addr [3];
    logic [31:0] dat  [3];
    logic [63:0] ir   [3];

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        wb_pipe_stage #(.XLEN(32), .MEM_LAT(g + 1)) u_dut (
            .clk(clk), .rst(rst), .stall(stall), .flush(flush),
            .in_valid(in_valid), .in_inst(in_inst), .in_alu(in_alu), .in_pc4(in_pc4),
            .in_imm(in_imm), .mem_rdata(mem_rdata), .haz_rs1(haz_rs1), .haz_rs2(haz_rs2),
            .wb_en(en[g]), .wb_addr(addr[g]), .wb_data(dat[g]),
            .load_hazard(haz[g]), .instret(ir[g])
        );
    end

    // Reference: every non-stalled edge appends one capture; an instance of latency L holds the
    // last L captures, its head being the oldest. killed[k] marks a flush kill seen by instance k.
    typedef struct {
        logic        v;
        logic [2:0]  killed;
        logic [31:0] inst, alu, pc4, imm;
    } rec_t;

    rec_t        hist[$];
    logic [63:0] m_ir [3];
    logic [6:0]  ops  [12];

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3);
        return {17'd0, f3, rd, op};
    endfunction

    function automatic bit head_of(input int k, output rec_t r);
        r = '{v: 1'b0, killed: 3'd0, inst: 32'd0, alu: 32'd0, pc4: 32'd0, imm: 32'd0};
        if (hist.size() < k + 1) return 1'b0;
        r = hist[hist.size() - (k + 1)];
        return r.v && !r.killed[k];
    endfunction

    function automatic void ref_wb(input rec_t r, input logic [31:0] rdata,
                                   output bit w, output logic [31:0] val);
        int unsigned off;
        logic [31:0] b, h;
        off = r.alu[1:0];
        b = (rdata >> (8 * off)) & 32'h0000_00FF;
        h = (rdata >> (8 * (off & 2))) & 32'h0000_FFFF;
        w = 1'b0;
        val = 32'd0;
        case (r.inst[6:0])
            7'h37:               begin w = 1'b1; val = r.imm; end
            7'h17, 7'h13, 7'h33: begin w = 1'b1; val = r.alu; end
            7'h6F, 7'h67:        begin w = 1'b1; val = r.pc4; end
            7'h03: begin
                case (r.inst[14:12])
                    3'd0: begin w = 1'b1; val = b[7] ? (b | 32'hFFFF_FF00) : b; end
                    3'd4: begin w = 1'b1; val = b; end
                    3'd1: begin w = 1'b1; val = h[15] ? (h | 32'hFFFF_0000) : h; end
                    3'd5: begin w = 1'b1; val = h; end
                    3'd2: begin w = 1'b1; val = rdata; end
                    default: w = 1'b0;
                endcase
            end
            default: w = 1'b0;
        endcase
    endfunction

    function automatic bit ref_haz(input int k);
        bit h = 1'b0;
        for (int j = 1; j <= k + 1; j++) begin
            if (hist.size() >= j) begin
                rec_t r = hist[hist.size() - j];
                if (r.v && !r.killed[k] && r.inst[6:0] == 7'h03 && r.inst[11:7] != 5'd0 &&
                    ((haz_rs1 != 5'd0 && haz_rs1 == r.inst[11:7]) ||
                     (haz_rs2 != 5'd0 && haz_rs2 == r.inst[11:7])))
                    h = 1'b1;
            end
        end
        return h;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < 3; k++) begin
            rec_t r;
            bit hv, w, dchk, e_haz;
            logic [31:0] val, e_dat;
            logic e_en;
            logic [4:0] e_addr;
            hv = head_of(k, r);
            ref_wb(r, mem_rdata, w, val);
            e_en = hv && w && !stall && (r.inst[11:7] != 5'd0);
            e_addr = hv ? r.inst[11:7] : 5'd0;
            e_haz = ref_haz(k);
            dchk = 1'b1;
            e_dat = 32'd0;
            if (rst) begin
                e_en = 1'b0; e_addr = 5'd0; e_haz = 1'b0;
            end else if (hv && e_en) begin
                e_dat = val;
            end else if (hv && !(r.inst[6:0] == 7'h03 && !w)) begin
                dchk = 1'b0;
            end
            chk($sformatf("wb_en_L%0d", k + 1), 64'(en[k]), 64'(e_en));
            chk($sformatf("wb_addr_L%0d", k + 1), 64'(addr[k]), 64'(e_addr));
            chk($sformatf("hazard_L%0d", k + 1), 64'(haz[k]), 64'(e_haz));
            chk($sformatf("instret_L%0d", k + 1), ir[k], m_ir[k]);
            if (dchk) chk($sformatf("wb_data_L%0d", k + 1), 64'(dat[k]), 64'(e_dat));
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            hist.delete();
            for (int k = 0; k < 3; k++) m_ir[k] = 64'd0;
        end else begin
            if (!stall) begin
                for (int k = 0; k < 3; k++) begin
                    rec_t r;
                    if (head_of(k, r)) m_ir[k] = m_ir[k] + 64'd1;
                end
            end
            if (flush) begin
                for (int k = 0; k < 3; k++) begin
                    for (int j = 1; j <= k; j++) begin
                        if (hist.size() >= j) begin
                            rec_t t = hist[hist.size() - j];
                            t.killed[k] = 1'b1;
                            hist[hist.size() - j] = t;
                        end
                    end
                end
            end
            if (!stall) begin
                rec_t n;
                n.v = in_valid & !flush;
                n.killed = 3'd0;
                n.inst = in_inst; n.alu = in_alu; n.pc4 = in_pc4; n.imm = in_imm;
                hist.push_back(n);
                if (hist.size() > 4) void'(hist.pop_front());
            end
        end
    endtask

    task automatic tick();
        #1;
        check_model();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] alu,
                         input logic [31:0] pc4, input logic [31:0] imm);
        in_valid = v; in_inst = inst; in_alu = alu; in_pc4 = pc4; in_imm = imm;
    endtask

    initial begin
        logic [63:0] base;
        logic [31:0] rnd;
        logic [2:0]  f3s  [5];
        logic [1:0]  offs [5];
        logic [31:0] exps [5];

        ops = '{7'h37, 7'h17, 7'h13, 7'h33, 7'h1B, 7'h3B, 7'h6F, 7'h67, 7'h03, 7'h03, 7'h23, 7'h73};
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        haz_rs1 = 5'd0; haz_rs2 = 5'd0; mem_rdata = 32'hDEAD_BEEF;
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        tick();
        rst = 1'b0;

        // LW through the 2-deep instance: no write before the head cycle
        drive(1'b1, mk(7'h03, 5'd5, 3'd2), 32'h100, 32'd0, 32'd0);
        tick();
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        #1 chk("lw_lat2_early_en", 64'(en[1]), 64'd0);
        tick();
        #1 chk("lw_lat2_en", 64'(en[1]), 64'd1);
        chk("lw_lat2_addr", 64'(addr[1]), 64'd5);
        chk("lw_lat2_data", 64'(dat[1]), 64'hDEAD_BEEF);
        tick();

        // Sub-word loads on the 1-deep instance
        mem_rdata = 32'h80FF_1234;
        f3s  = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd7};
        offs = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd0};
        exps = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF, 32'h0000_0000};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, mk(7'h03, 5'd9, f3s[i]), 32'(offs[i]), 32'd0, 32'd0);
            tick();
            drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
            #1 chk($sformatf("load_f3_%0d_en", f3s[i]), 64'(en[0]), (i == 4) ? 64'd0 : 64'd1);
            chk($sformatf("load_f3_%0d_data", f3s[i]), 64'(dat[0]), 64'(exps[i]));
        end
        tick();

        // ADDI x0, SW, JAL x1: one write, three retirements
        drive(1'b1, mk(7'h13, 5'd0, 3'd0), 32'h55, 32'd0, 32'd0);
        tick();
        base = m_ir[0];
        drive(1'b1, mk(7'h23, 5'd4, 3'd2), 32'h20, 32'd0, 32'd0);
        #1 chk("addi_x0_en", 64'(en[0]), 64'd0);
        tick();
        drive(1'b1, mk(7'h6F, 5'd1, 3'd0), 32'd0, 32'h40, 32'd0);
        #1 chk("sw_en", 64'(en[0]), 64'd0);
        tick();
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        #1 chk("jal_en", 64'(en[0]), 64'd1);
        chk("jal_data", 64'(dat[0]), 64'h40);
        tick();
        #1 chk("instret_plus3", ir[0], base + 64'd3);

        // Stall a full 3-deep pipeline for three cycles
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, mk(7'h13, 5'(10 + i), 3'd0), 32'(16 + i), 32'd0, 32'd0);
            tick();
        end
        base = m_ir[2];
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, mk(7'h13, 5'd20, 3'd0), 32'hBAD, 32'd0, 32'd0);
            #1 chk("stall_en", 64'(en[2]), 64'd0);
            chk("stall_instret", ir[2], base);
            tick();
        end
        stall = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            #1 chk("unstall_en", 64'(en[2]), 64'd1);
            chk("unstall_order", 64'(addr[2]), 64'(10 + i));
            tick();
        end

        // Flush a full 3-deep pipeline: only the head survives
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, mk(7'h13, 5'(13 + i), 3'd0), 32'(32 + i), 32'd0, 32'd0);
            tick();
        end
        base = m_ir[2];
        flush = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        #1 chk("flush_head_en", 64'(en[2]), 64'd1);
        chk("flush_head_addr", 64'(addr[2]), 64'd13);
        tick();
        flush = 1'b0;
        #1 chk("flush_kill1_en", 64'(en[2]), 64'd0);
        tick();
        #1 chk("flush_kill2_en", 64'(en[2]), 64'd0);
        chk("flush_instret", ir[2], base + 64'd1);
        tick();

        // Load-use hazard, then reset mid-flight
        drive(1'b1, mk(7'h03, 5'd7, 3'd2), 32'd0, 32'd0, 32'd0);
        tick();
        drive(1'b1, mk(7'h03, 5'd0, 3'd2), 32'd0, 32'd0, 32'd0);
        haz_rs1 = 5'd3; haz_rs2 = 5'd7;
        #1 chk("haz_rs2_hit", 64'(haz[2]), 64'd1);
        haz_rs2 = 5'd0;
        #1 chk("haz_rs2_zero", 64'(haz[2]), 64'd0);
        tick();
        haz_rs1 = 5'd7;
        #1 chk("haz_rs1_hit", 64'(haz[2]), 64'd1);
        haz_rs1 = 5'd0;
        #1 chk("haz_rd_zero", 64'(haz[0]), 64'd0);
        drive(1'b1, mk(7'h03, 5'd8, 3'd2), 32'd0, 32'd0, 32'd0);
        tick();
        haz_rs1 = 5'd8;
        rst = 1'b1;
        tick();
        #1 chk("rst_en", 64'(en), 64'd0);
        chk("rst_haz", 64'(haz), 64'd0);
        for (int k = 0; k < 3; k++) begin
            chk("rst_instret", ir[k], 64'd0);
            chk("rst_data", 64'(dat[k]), 64'd0);
        end
        rst = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            #1 chk("post_rst_en", 64'(en), 64'd0);
            tick();
        end

        // Randomised traffic against the reference model
        for (int n = 0; n < 500; n++) begin
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 9) == 0);
            rst   = ($urandom_range(0, 99) == 0);
            if (!stall) mem_rdata = $urandom();
            haz_rs1 = 5'($urandom_range(0, 15));
            haz_rs2 = 5'($urandom_range(0, 15));
            rnd = $urandom();
            drive($urandom_range(0, 3) != 0,
                  {rnd[31:15], 3'($urandom_range(0, 7)), 5'($urandom_range(0, 15)),
                   ops[$urandom_range(0, 11)]},
                  $urandom(), $urandom(), $urandom());
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
